// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in ADJUST.
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, CALC, ADJUST, DONE} state_t;

    localparam int CW = $clog2(ITER) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;
    logic [31:0]   op_m;
    logic [31:0]   a_raw;
    logic          op_div;
    logic          q_neg;
    logic          r_neg;
    logic          b_zero;
    logic          busy;
    logic          done;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic          is_signed;
    logic [31:0]   a_abs;
    logic [31:0]   b_abs;
    logic [32:0]   mul_sum;
    logic [32:0]   div_r;
    logic [32:0]   div_diff;
    logic [63:0]   next_acc;
    logic          accept;

    always_comb begin
        is_signed = ~MDOp[0];
        a_abs     = (is_signed && A[31]) ? (32'd0 - A) : A;
        b_abs     = (is_signed && B[31]) ? (32'd0 - B) : B;
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, op_m};
        // Partial remainder with the next dividend bit shifted in.
        div_r     = acc[63:31];
        div_diff  = div_r - {1'b0, op_m};
        next_acc  = acc;
        if (op_div) begin
            if (div_r >= {1'b0, op_m})
                next_acc = {div_diff[31:0], acc[30:0], 1'b1};
            else
                next_acc = {div_r[31:0], acc[30:0], 1'b0};
        end else begin
            if (acc[0])
                next_acc = {mul_sum, acc[31:1]};
            else
                next_acc = {1'b0, acc[63:32], acc[31:1]};
        end
        accept = start && !busy && (state == IDLE || state == DONE);
    end

    // busy/done are registered from the previous state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            op_m   <= '0;
            a_raw  <= '0;
            op_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= (state == CALC) || (state == ADJUST);
            done <= (state == DONE);
            if (!busy) begin
                if (HIWrite) hi <= WriteData;
                if (LOWrite) lo <= WriteData;
            end
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_div <= MDOp[1];
                        a_raw  <= A;
                        b_zero <= (B == 32'd0);
                        q_neg  <= is_signed && (A[31] ^ B[31]);
                        r_neg  <= is_signed && A[31];
                        op_m   <= MDOp[1] ? b_abs : a_abs;
                        acc    <= MDOp[1] ? {32'd0, a_abs} : {32'd0, b_abs};
                        cnt    <= '0;
                        state  <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= next_acc;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= ADJUST;
                end
                ADJUST: begin
                    if (op_div) begin
                        if (b_zero) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= a_raw;
                        end else begin
                            lo <= q_neg ? (32'd0 - acc[31:0]) : acc[31:0];
                            hi <= r_neg ? (32'd0 - acc[63:32]) : acc[63:32];
                        end
                    end else begin
                        {hi, lo} <= q_neg ? (64'd0 - acc) : acc;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = busy;
    assign Done      = done;
    assign HI        = hi;
    assign LO        = lo;
    assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, MTHI/MTLO,
// start/write interference, mid-operation reset and random ops against a model.
module tb_mult_div_unit;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  MDOp = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        HIWrite = 1'b0;
    logic        LOWrite = 1'b0;
    logic [31:0] WriteData = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ops_done = 0;

    mult_div_unit #(.ITER(ITER)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (Done) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int intr_at, input bit wr_start);
        int lat;
        int busy_cyc;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        if (wr_start) begin HIWrite = 1'b1; WriteData = 32'h1234_5678; end
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; HIWrite = 1'b0;
        if (wr_start) check_eq("mthi_with_start", {32'd0, HI}, 64'h1234_5678);
        lat = 0;
        busy_cyc = 0;
        while (!Done && lat < 100) begin
            if (Busy) busy_cyc++;
            if (lat == intr_at) begin
                start = 1'b1; MDOp = 2'b11; A = 32'd100; B = 32'd7;
                HIWrite = 1'b1; LOWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(ITER + 2));
        check_eq("busy_cycles", 64'(busy_cyc), 64'(ITER + 1));
        check_eq("busy_at_done", {63'd0, Busy}, 64'd0);
        e = exp_q.pop_front();
        check_eq("hi", {32'd0, HI}, {32'd0, e[63:32]});
        check_eq("lo", {32'd0, LO}, {32'd0, e[31:0]});
        ops_done++;
        @(negedge clk);
        check_eq("done_pulse_width", {63'd0, Done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int d0;

        do_reset();
        check_eq("rst_busy", {63'd0, Busy}, 64'd0);
        check_eq("rst_done", {63'd0, Done}, 64'd0);
        check_eq("rst_hi", {32'd0, HI}, 64'd0);
        check_eq("rst_lo", {32'd0, LO}, 64'd0);

        HIWrite = 1'b1; WriteData = 32'hAAAA_5555;
        @(negedge clk);
        HIWrite = 1'b0; LOWrite = 1'b1; WriteData = 32'h0F0F_F0F0;
        @(negedge clk);
        LOWrite = 1'b0;
        check_eq("mthi", {32'd0, HI}, 64'hAAAA_5555);
        check_eq("mtlo", {32'd0, LO}, 64'h0F0F_F0F0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, -1, 1'b1);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB}, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, 1'b0);
        run_op(2'b11, 32'd100,       32'd7,         {32'd2, 32'd14},                -1, 1'b0);
        run_op(2'b11, 32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF},         -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},         -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF7, 32'd0,         {32'hFFFF_FFF7, 32'hFFFF_FFFF}, -1, 1'b0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},         -1, 1'b0);

        do_reset();
        run_op(2'b01, 32'd2, 32'd3, {32'd0, 32'd6}, 10, 1'b0);

        @(negedge clk);
        start = 1'b1; MDOp = 2'b10; A = 32'hFFFF_FF9C; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", {63'd0, Busy}, 64'd0);
        check_eq("abort_hi", {32'd0, HI}, 64'd0);
        check_eq("abort_lo", {32'd0, LO}, 64'd0);
        repeat (40) @(negedge clk);
        check_eq("abort_no_done", 64'(done_cnt), 64'(d0));
        check_eq("abort_hi_late", {32'd0, HI}, 64'd0);
        check_eq("abort_lo_late", {32'd0, LO}, 64'd0);
        run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom();
            rb  = (i == 3) ? 32'd0 : 32'($urandom_range(0, 65535)) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 : 32'd0);
            run_op(rop, ra, rb, model(rop, ra, rb), -1, 1'b0);
        end

        check_eq("done_total", 64'(done_cnt), 64'(ops_done));
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
